reg_writeback: RTL and testbench

Writeback sequencer that drives the register-file write port (rd, rd_value, we) from two result producers: the ALU and the load unit.
- Accepts results over valid/ready handshakes and arbitrates round-robin.
- Registers exactly one write per cycle toward the register file.
- Suppresses writes to x0.
- Keeps a busy scoreboard of destination registers that the issue logic reads for RAW stalls.

---
 rtl/reg_writeback.sv | 145 ++++++++++++++
 tb/tb_reg_writeback.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Writeback sequencer: round-robin arbitration between the ALU and load unit
// results, one registered register-file write per cycle, plus a busy scoreboard.
module reg_writeback #(
    parameter int XLEN   = 32,
    parameter int N_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_value,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rd,
    input  logic [XLEN-1:0]   ld_value,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic [N_REGS-1:0] busy,
    output logic [4:0]        rd,
    output logic [XLEN-1:0]   rd_value,
    output logic              we
);

    typedef enum logic {
        PREF_ALU = 1'b0,
        PREF_LD  = 1'b1
    } pref_e;

    pref_e              r_ptr;
    pref_e              w_ptr_next;
    logic               w_alu_grant;
    logic               w_ld_grant;
    logic               w_accept;
    logic [4:0]         w_sel_rd;
    logic [XLEN-1:0]    w_sel_value;

    logic               r_we;
    logic [4:0]         r_rd;
    logic [XLEN-1:0]    r_rd_value;
    logic [N_REGS-1:0]  r_busy;
    logic [N_REGS-1:0]  w_set_mask;
    logic [N_REGS-1:0]  w_clr_mask;
    logic [N_REGS-1:0]  w_busy_next;

    // Arbitration pointer register: favours the ALU out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PREF_ALU;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    // Grant decode and next pointer; pointer moves only when a transfer is accepted.
    always_comb begin
        w_alu_grant = 1'b0;
        w_ld_grant  = 1'b0;
        w_ptr_next  = r_ptr;
        case ({alu_valid, ld_valid})
            2'b10: begin
                w_alu_grant = 1'b1;
                w_ptr_next  = PREF_LD;
            end
            2'b01: begin
                w_ld_grant = 1'b1;
                w_ptr_next = PREF_ALU;
            end
            2'b11: begin
                if (r_ptr == PREF_ALU) begin
                    w_alu_grant = 1'b1;
                    w_ptr_next  = PREF_LD;
                end else begin
                    w_ld_grant = 1'b1;
                    w_ptr_next = PREF_ALU;
                end
            end
            default: begin
                w_alu_grant = 1'b0;
                w_ld_grant  = 1'b0;
                w_ptr_next  = r_ptr;
            end
        endcase
    end

    assign alu_ready = w_alu_grant;
    assign ld_ready  = w_ld_grant;
    assign w_accept  = w_alu_grant | w_ld_grant;

    // Result mux for the granted source.
    always_comb begin
        w_sel_rd    = alu_rd;
        w_sel_value = alu_value;
        if (w_ld_grant) begin
            w_sel_rd    = ld_rd;
            w_sel_value = ld_value;
        end else begin
            w_sel_rd    = alu_rd;
            w_sel_value = alu_value;
        end
    end

    // Register-file write port; writes to x0 complete the handshake but never assert we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_rd       <= 5'd0;
            r_rd_value <= '0;
        end else if (w_accept) begin
            r_we       <= (w_sel_rd != 5'd0);
            r_rd       <= w_sel_rd;
            r_rd_value <= w_sel_value;
        end else begin
            r_we <= 1'b0;
        end
    end

    // Scoreboard set/clear masks; index 0 and indices beyond N_REGS never match.
    always_comb begin
        w_set_mask    = '0;
        w_clr_mask    = '0;
        for (int i = 1; i < N_REGS; i++) begin
            w_set_mask[i] = issue_valid && ({27'd0, issue_rd} == 32'(i));
            w_clr_mask[i] = w_accept && ({27'd0, w_sel_rd} == 32'(i));
        end
        // Set is applied after clear so a younger issue to the same register wins.
        w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_next[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign we       = r_we;
    assign rd       = r_rd;
    assign rd_value = r_rd_value;
    assign busy     = r_busy;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback: reset, single write, contention,
// x0 suppression, scoreboard set/clear priority and reset mid-stream.
module tb_reg_writeback;

    localparam int XLEN   = 32;
    localparam int N_REGS = 32;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_value;
    logic              ld_valid;
    logic              ld_ready;
    logic [4:0]        ld_rd;
    logic [XLEN-1:0]   ld_value;
    logic              issue_valid;
    logic [4:0]        issue_rd;
    logic [N_REGS-1:0] busy;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rd_value;
    logic              we;

    int n_checks;
    int n_errors;

    reg_writeback #(.XLEN(XLEN), .N_REGS(N_REGS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_value   (alu_value),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_value    (ld_value),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .rd          (rd),
        .rd_value    (rd_value),
        .we          (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b1;
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_value   = 32'd0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_value    = 32'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;

        // 1. Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_rd", {59'd0, rd}, 64'd0);
        chk("rst_val", {32'd0, rd_value}, 64'd0);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_we", {63'd0, we}, 64'd0);
        chk("idle_ready", {62'd0, alu_ready, ld_ready}, 64'd0);

        // 2. Single ALU write.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_value = 32'h0000_00FF;
        #1;
        chk("alu_only_ready", {62'd0, alu_ready, ld_ready}, 64'd2);
        step();
        alu_valid = 1'b0;
        chk("alu_we", {63'd0, we}, 64'd1);
        chk("alu_rd", {59'd0, rd}, 64'd5);
        chk("alu_val", {32'd0, rd_value}, 64'hFF);
        step();
        chk("alu_we_drop", {63'd0, we}, 64'd0);

        // 4. x0 suppression (also leaves the pointer favouring the ALU).
        ld_valid = 1'b1; ld_rd = 5'd0; ld_value = 32'hDEAD_BEEF;
        #1;
        chk("x0_ready", {62'd0, alu_ready, ld_ready}, 64'd1);
        step();
        ld_valid = 1'b0;
        chk("x0_we", {63'd0, we}, 64'd0);
        chk("x0_busy", {32'd0, busy}, 64'd0);

        // 3. Contention: grants alternate ALU, load, ALU, load with no bubble.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 32'h11;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_value  = 32'h22;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("cont_ready", {62'd0, alu_ready, ld_ready}, (k % 2 == 0) ? 64'd2 : 64'd1);
            step();
            chk("cont_we", {63'd0, we}, 64'd1);
            chk("cont_rd", {59'd0, rd}, (k % 2 == 0) ? 64'd3 : 64'd4);
            chk("cont_val", {32'd0, rd_value}, (k % 2 == 0) ? 64'h11 : 64'h22);
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        step();
        chk("cont_we_drop", {63'd0, we}, 64'd0);

        // 5. Scoreboard.
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        chk("sb_set7", {32'd0, busy}, 64'h80);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_value = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        chk("sb_set_wins", {32'd0, busy}, 64'h80);
        chk("sb_wr7_rd", {59'd0, rd}, 64'd7);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_value = 32'h78;
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        chk("sb_set9_clr7", {32'd0, busy}, 64'h200);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_value = 32'h99;
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        ld_valid = 1'b0; issue_valid = 1'b0;
        chk("sb_clr9_x0_issue", {32'd0, busy}, 64'd0);
        chk("sb_ld_rd", {59'd0, rd}, 64'd9);

        // 6. Reset mid-stream: accept at edge N, reset before N+1.
        alu_valid = 1'b1; alu_rd = 5'd12; alu_value = 32'hABC;
        issue_valid = 1'b1; issue_rd = 5'd12;
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        chk("mid_pre_we", {63'd0, we}, 64'd1);
        chk("mid_pre_busy", {32'd0, busy}, 64'h1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_we", {63'd0, we}, 64'd0);
        chk("mid_busy", {32'd0, busy}, 64'd0);
        chk("mid_val", {32'd0, rd_value}, 64'd0);
        step();
        chk("mid_edge_we", {63'd0, we}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("mid_after_we", {63'd0, we}, 64'd0);
        chk("mid_after_rd", {59'd0, rd}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
